// File: rtl/filter_accel_acc_norm.sv
// Tap-product accumulator with rounding, normalising shift and unsigned clamp.
// Optional rounding adder enabled by defining FILTER_ACC_ROUND_EN.
module filter_accel_acc_norm #(
  parameter int unsigned TAPS   = 9,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned PROD_W = 17,
  parameter int unsigned PIX_W  = 11,
  parameter int unsigned ACC_W  = PROD_W + 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              err_last
);

  localparam int unsigned CNT_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TAPS - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PIX_W-1:0]        pix_data_q, pix_data_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    err_q, err_d;

  logic                    last_tap;
  logic                    accept;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   shifted;
  logic [PIX_W-1:0]        pix_clamp;

  assign last_tap   = (cnt_q == LastCnt);
  // Only the closing tap needs a free output register.
  assign prod_ready = !(last_tap && pix_valid_q && !pix_ready);
  assign accept     = prod_valid && prod_ready;

  assign prod_ext = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign sum      = acc_q + prod_ext;
  // One extra bit so the rounding constant cannot wrap a maximal sum.
  assign sum_ext  = {sum[ACC_W-1], sum};

`ifdef FILTER_ACC_ROUND_EN
  localparam logic [ACC_W:0] RoundAdd = (ACC_W + 1)'(2 ** (SHIFT - 1));
  assign rounded = sum_ext + RoundAdd;
`else
  assign rounded = sum_ext;
`endif

  assign shifted = rounded >>> SHIFT;

  always_comb begin
    if (shifted[ACC_W]) begin
      pix_clamp = '0;
    end else if (|shifted[ACC_W-1:PIX_W]) begin
      pix_clamp = '1;
    end else begin
      pix_clamp = shifted[PIX_W-1:0];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    err_d       = err_q;
    if (pix_valid_q && pix_ready) begin
      pix_valid_d = 1'b0;
    end
    if (accept) begin
      if (prod_last != last_tap) begin
        err_d = 1'b1;
      end
      if (last_tap) begin
        acc_d       = '0;
        cnt_d       = '0;
        pix_data_d  = pix_clamp;
        pix_valid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      err_q       <= err_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign err_last  = err_q;

endmodule

// File: tb/tb_filter_accel_acc_norm.sv
// Self-checking bench for filter_accel_acc_norm: directed scenarios plus a
// transaction-level model that tracks group sums and pending output pixels.
module tb_filter_accel_acc_norm;

  localparam int TAPS    = 9;
  localparam int SHIFT   = 4;
  localparam int PROD_W  = 17;
  localparam int PIX_W   = 11;
  localparam int PIX_MAX = 2047;
`ifdef FILTER_ACC_ROUND_EN
  localparam int RND = 8;
`else
  localparam int RND = 0;
`endif

  logic              ap_clk;
  logic              ap_rst_n;
  logic [PROD_W-1:0] prod_data;
  logic              prod_valid;
  logic              prod_last;
  logic              prod_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              err_last;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int acc_m = 0;
  int cnt_m = 0;
  bit err_m = 1'b0;
  int q[$];
  bit rand_done = 1'b0;

  filter_accel_acc_norm dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .err_last   (err_last)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic int norm(input int s);
    int v;
    v = (s + RND) >>> SHIFT;
    if (v < 0) return 0;
    if (v > PIX_MAX) return PIX_MAX;
    return v;
  endfunction

  // Samples on the falling edge; updates model with handshakes of the coming rising edge.
  task automatic monitor();
    bit exp_rdy;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        acc_m = 0;
        cnt_m = 0;
        err_m = 1'b0;
        q.delete();
      end else begin
        checks++;
        if (pix_valid !== (q.size() > 0)) begin
          errors++;
          $display("FAIL mon_pix_valid: got %b want %b at %0t", pix_valid, q.size() > 0, $time);
        end
        if (q.size() > 0) begin
          checks++;
          if (pix_data !== PIX_W'(q[0])) begin
            errors++;
            $display("FAIL mon_pix_data: got %0d want %0d at %0t", pix_data, q[0], $time);
          end
        end
        exp_rdy = !(cnt_m == TAPS - 1 && q.size() > 0 && !pix_ready);
        checks++;
        if (prod_ready !== exp_rdy) begin
          errors++;
          $display("FAIL mon_prod_ready: got %b want %b at %0t", prod_ready, exp_rdy, $time);
        end
        checks++;
        if (err_last !== err_m) begin
          errors++;
          $display("FAIL mon_err_last: got %b want %b at %0t", err_last, err_m, $time);
        end
        if (q.size() > 0 && pix_ready) void'(q.pop_front());
        if (prod_valid && exp_rdy) begin
          if (prod_last != (cnt_m == TAPS - 1)) err_m = 1'b1;
          acc_m += int'($signed(prod_data));
          cnt_m++;
          if (cnt_m == TAPS) begin
            q.push_back(norm(acc_m));
            acc_m = 0;
            cnt_m = 0;
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_prod(input int v, input bit lst);
    prod_valid = 1'b1;
    prod_data  = PROD_W'(v);
    prod_last  = lst;
    for (int i = 0; ; i++) begin
      @(negedge ap_clk);
      if (prod_ready) break;
      if (i > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: prod_ready stuck at %b, wanted 1", prod_ready);
        break;
      end
    end
    @(posedge ap_clk);
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic send_group(input int base, input int last_val, input int last_pos);
    for (int t = 0; t < TAPS; t++) begin
      send_prod((t == TAPS - 1) ? last_val : base, t == last_pos);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== '0 || err_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d err=%b want 0/0/0", pix_valid, pix_data,
               err_last);
    end
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (prod_ready !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b want 1/0", prod_ready, pix_valid);
    end
  endtask

  task automatic test_round();
    int exp_v;
    exp_v = (RND != 0) ? 57 : 56;
    send_group(100, 108, TAPS - 1);
    @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== PIX_W'(exp_v)) begin
      errors++;
      $display("FAIL round_pix: valid=%b data=%0d want 1/%0d", pix_valid, pix_data, exp_v);
    end
  endtask

  task automatic test_negative();
    send_group(-50, -50, TAPS - 1);
    @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== '0 || err_last !== 1'b0) begin
      errors++;
      $display("FAIL negative_clamp: valid=%b data=%0d err=%b want 1/0/0", pix_valid, pix_data,
               err_last);
    end
  endtask

  task automatic test_clamp();
    send_group(4000, 4000, TAPS - 1);
    @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== PIX_W'(PIX_MAX)) begin
      errors++;
      $display("FAIL high_clamp: valid=%b data=%0d want 1/%0d", pix_valid, pix_data, PIX_MAX);
    end
  endtask

  task automatic test_back_to_back();
    int exp_a;
    int exp_b;
    exp_a = (1800 + RND) >>> SHIFT;
    exp_b = (2700 + RND) >>> SHIFT;
    @(posedge ap_clk);
    #1;
    pix_ready = 1'b0;
    send_group(200, 200, TAPS - 1);
    fork
      send_group(300, 300, TAPS - 1);
      begin
        repeat (14) @(negedge ap_clk);
        checks++;
        if (prod_ready !== 1'b0 || pix_valid !== 1'b1 || pix_data !== PIX_W'(exp_a)) begin
          errors++;
          $display("FAIL stall_hold: ready=%b valid=%b data=%0d want 0/1/%0d", prod_ready,
                   pix_valid, pix_data, exp_a);
        end
        @(posedge ap_clk);
        #1;
        pix_ready = 1'b1;
      end
    join
    @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== PIX_W'(exp_b)) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%0d want 1/%0d", pix_valid, pix_data, exp_b);
    end
    @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b want 0", pix_valid);
    end
  endtask

  task automatic test_last_err();
    send_group(50, 50, 4);
    @(negedge ap_clk);
    checks++;
    if (err_last !== 1'b1 || pix_valid !== 1'b1 || pix_data !== PIX_W'(28)) begin
      errors++;
      $display("FAIL last_err: err=%b valid=%b data=%0d want 1/1/28", err_last, pix_valid,
               pix_data);
    end
    repeat (4) @(negedge ap_clk);
    checks++;
    if (err_last !== 1'b1) begin
      errors++;
      $display("FAIL last_err_sticky: err=%b want 1", err_last);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge ap_clk);
    #1;
    pix_ready = 1'b0;
    send_group(10, 10, TAPS - 1);
    for (int t = 0; t < 4; t++) send_prod(999, 1'b0);
    #3;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== '0 || err_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%0d err=%b want 0/0/0", pix_valid, pix_data,
               err_last);
    end
    @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    pix_ready = 1'b1;
    send_group(160, 160, TAPS - 1);
    @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== PIX_W'(90)) begin
      errors++;
      $display("FAIL post_reset_pix: valid=%b data=%0d want 1/90", pix_valid, pix_data);
    end
  endtask

  task automatic test_random();
    @(posedge ap_clk);
    #1;
    rand_done = 1'b0;
    fork
      begin
        for (int g = 0; g < 20; g++) begin
          for (int t = 0; t < TAPS; t++) begin
            int v;
            bit lst;
            v   = int'($urandom_range(0, 131071)) - 65536;
            lst = (t == TAPS - 1);
            if ($urandom_range(0, 9) == 0) lst = !lst;
            send_prod(v, lst);
            repeat ($urandom_range(0, 2)) @(posedge ap_clk);
            #0;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge ap_clk);
          #1;
          pix_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge ap_clk);
    #1;
    pix_ready = 1'b1;
    repeat (4) @(negedge ap_clk);
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: valid=%b want 0", pix_valid);
    end
  endtask

  initial begin
    ap_rst_n   = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    prod_last  = 1'b0;
    pix_ready  = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    @(posedge ap_clk);
    #1;
    test_round();
    @(posedge ap_clk);
    #1;
    test_negative();
    @(posedge ap_clk);
    #1;
    test_clamp();
    test_back_to_back();
    @(posedge ap_clk);
    #1;
    test_last_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
